// File: rtl/risc_pkg.sv
// risc_pkg: constants shared by the RISC control path.
// Holds the sequencer state codes, the PC-source and counter-selector
// encodings, the "no branch" code and the opcode/funct values that the
// control decoder matches. Also holds pc_select(), the PC-source priority
// rule that is applied in the WB step.
package risc_pkg;

  // Sequencer states. Plain constants keep the encoding visible to the
  // legacy tools that probe the state register.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_MEM    = 3'd4;
  localparam state_t S_WB     = 3'd5;
  localparam state_t S_ERR    = 3'd6;

  // pc_sel encodings driven to the PC mux
  localparam logic [1:0] PCSEL_SEQ    = 2'b00;
  localparam logic [1:0] PCSEL_JUMP   = 2'b01;
  localparam logic [1:0] PCSEL_REG    = 2'b10;
  localparam logic [1:0] PCSEL_BRANCH = 2'b11;

  // Decoder counter_selector encodings
  localparam logic [1:0] CSEL_SEQ  = 2'b00;
  localparam logic [1:0] CSEL_JUMP = 2'b01;
  localparam logic [1:0] CSEL_REG  = 2'b10;

  // Decoder branch codes
  localparam logic [3:0] BR_NONE = 4'b1001;
  localparam logic [3:0] BR_EQ   = 4'b0001;
  localparam logic [3:0] BR_NE   = 4'b0010;

  // Opcode / funct values recognised by the control decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Decoder outputs captured at the end of DECODE
  typedef struct packed {
    logic       reg_write;
    logic       data_read;
    logic       data_write;
    logic [3:0] branch_type;
    logic [1:0] counter_selector;
  } dec_ctrl_t;

  // Explicit jumps outrank a taken conditional branch.
  function automatic logic [1:0] pc_select(input logic [1:0] csel,
                                           input logic [3:0] br_type,
                                           input logic       taken);
    logic [1:0] sel;
    sel = PCSEL_SEQ;
    if (csel == CSEL_JUMP)
      sel = PCSEL_JUMP;
    else if (csel == CSEL_REG)
      sel = PCSEL_REG;
    else if ((br_type != BR_NONE) && taken)
      sel = PCSEL_BRANCH;
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for a memory acknowledge.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear_i     restart the count from zero (wins over count_i)
//   count_i     one more cycle passed without an acknowledge
//   expire_o    count has reached TIMEOUT-1
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holds at LAST so the counter never wraps while the owner reacts.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (count_i && !expire_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/risc_sequencer.sv
// risc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, halt_req      run control (start only in IDLE, halt only in WB)
//   imem_req/imem_ack    instruction fetch handshake; ir_load strobe
//   dec_*                control-decoder outputs, captured at end of DECODE
//   branch_taken         flag-unit condition, used live in WB
//   dmem_req/we/ack      data memory handshake
//   reg_we, pc_en, pc_sel  writeback strobes and PC source
//   busy, bus_err        status; bus_err is sticky until reset
//   retired              count of completed instructions (wraps)
module risc_sequencer
  import risc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic             dec_reg_write,
  input  logic             dec_data_read,
  input  logic             dec_data_write,
  input  logic [3:0]       dec_branch_type,
  input  logic [1:0]       dec_counter_selector,
  input  logic             branch_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             reg_we,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             busy,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  dec_ctrl_t        ctrl_q, ctrl_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             imem_req_q, dmem_req_q, dmem_we_q;
  logic             tmr_clear, tmr_count, tmr_expire;

  // An ack in the expiry cycle is checked first, so it wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
                else if (tmr_expire) state_d = S_ERR;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (ctrl_q.data_read || ctrl_q.data_write) ? S_MEM : S_WB;
      S_MEM:    if (dmem_ack) state_d = S_WB;
                else if (tmr_expire) state_d = S_ERR;
      S_WB:     state_d = halt_req ? S_IDLE : S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  // One timer serves both wait states; it restarts on every entry.
  assign tmr_clear = ((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q);
  assign tmr_count = ((state_q == S_FETCH) && !imem_ack) ||
                     ((state_q == S_MEM)   && !dmem_ack);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (tmr_clear),
    .count_i  (tmr_count),
    .expire_o (tmr_expire)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    if (state_q == S_DECODE)
      ctrl_d = '{reg_write:        dec_reg_write,
                 data_read:        dec_data_read,
                 data_write:       dec_data_write,
                 branch_type:      dec_branch_type,
                 counter_selector: dec_counter_selector};
  end

  always_comb begin
    retired_d = retired_q;
    if (state_q == S_WB)
      retired_d = retired_q + 1'b1;
  end

  // Requests are flops that track the next state, so they rise on the first
  // wait cycle and fall right after the ack. A load wins over a store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      retired_q  <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      retired_q  <= retired_d;
      imem_req_q <= (state_d == S_FETCH);
      dmem_req_q <= (state_d == S_MEM);
      dmem_we_q  <= (state_d == S_MEM) && ctrl_q.data_write && !ctrl_q.data_read;
    end
  end

  assign imem_req = imem_req_q;
  assign dmem_req = dmem_req_q;
  assign dmem_we  = dmem_we_q;
  assign ir_load  = (state_q == S_FETCH) && imem_ack;
  assign reg_we   = (state_q == S_WB) && ctrl_q.reg_write;
  assign pc_en    = (state_q == S_WB);
  assign pc_sel   = (state_q == S_WB)
                    ? pc_select(ctrl_q.counter_selector, ctrl_q.branch_type, branch_taken)
                    : PCSEL_SEQ;
  assign busy     = (state_q != S_IDLE) && (state_q != S_ERR);
  assign bus_err  = (state_q == S_ERR);
  assign retired  = retired_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// tb_risc_sequencer: self-checking bench for risc_sequencer.
// Runs a table of hand-computed instruction vectors, a randomized stream
// checked against a rule-level model, and hand-written sequences for
// reset during MEM and the fetch timeout.
module tb_risc_sequencer;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, halt_req;
  logic             imem_req, imem_ack, ir_load;
  logic             dec_reg_write, dec_data_read, dec_data_write;
  logic [3:0]       dec_branch_type;
  logic [1:0]       dec_counter_selector;
  logic             branch_taken;
  logic             dmem_req, dmem_we, dmem_ack;
  logic             reg_we, pc_en;
  logic [1:0]       pc_sel;
  logic             busy, bus_err;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;
  int modelRetired = 0;

  typedef struct {
    string    name;
    bit       rw, rd, wr;
    bit [3:0] br;
    bit [1:0] cs;
    bit       taken;
    int       iDly, dDly;
    bit       halt;
    bit [1:0] expSel;
    bit       expRegWe;
    bit       expWe;
    int       expCycles;
  } vec_t;

  vec_t vecs[9];

  risc_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .halt_req             (halt_req),
    .imem_req             (imem_req),
    .imem_ack             (imem_ack),
    .ir_load              (ir_load),
    .dec_reg_write        (dec_reg_write),
    .dec_data_read        (dec_data_read),
    .dec_data_write       (dec_data_write),
    .dec_branch_type      (dec_branch_type),
    .dec_counter_selector (dec_counter_selector),
    .branch_taken         (branch_taken),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_ack             (dmem_ack),
    .reg_we               (reg_we),
    .pc_en                (pc_en),
    .pc_sel               (pc_sel),
    .busy                 (busy),
    .bus_err              (bus_err),
    .retired              (retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Expectations straight from the written rules: explicit jumps first,
  // then a real taken branch; memory adds one cycle plus its wait.
  function automatic vec_t modelVec(input vec_t v);
    vec_t r;
    r = v;
    if (v.cs == 2'b01)                          r.expSel = 2'b01;
    else if (v.cs == 2'b10)                     r.expSel = 2'b10;
    else if (v.br != 4'b1001 && v.taken)        r.expSel = 2'b11;
    else                                        r.expSel = 2'b00;
    r.expRegWe  = v.rw;
    r.expWe     = v.wr && !v.rd;
    r.expCycles = 4 + v.iDly + ((v.rd || v.wr) ? 1 + v.dDly : 0);
    return r;
  endfunction

  task automatic startRun();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge with the DUT in its first FETCH cycle. Returns at
  // the negedge after WB.
  task automatic applyStimulus(input vec_t v, input bit noise);
    int n, irCnt, regCnt, pcCnt, imemCyc, dmemCyc, fWait, dWait, weBad;
    bit done;
    logic [1:0] selSeen;
    bit isMem;
    n = 0; irCnt = 0; regCnt = 0; pcCnt = 0; imemCyc = 0; dmemCyc = 0;
    fWait = 0; dWait = 0; weBad = 0; done = 0; selSeen = 2'b00;
    isMem = v.rd || v.wr;
    dec_reg_write = v.rw; dec_data_read = v.rd; dec_data_write = v.wr;
    dec_branch_type = v.br; dec_counter_selector = v.cs;
    branch_taken = v.taken; halt_req = v.halt;
    while (!done && n < 40) begin
      n++;
      imem_ack = imem_req && (fWait == v.iDly);
      dmem_ack = dmem_req && (dWait == v.dDly);
      if (noise) begin
        if (!imem_req) imem_ack = 1'($urandom_range(0, 1));
        if (!dmem_req) dmem_ack = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      if (imem_req) fWait++;
      if (dmem_req) dWait++;
      #1;
      if (imem_req) imemCyc++;
      if (dmem_req) begin
        dmemCyc++;
        if (dmem_we !== v.expWe) weBad++;
      end
      if (ir_load) irCnt++;
      if (reg_we)  regCnt++;
      if (pc_en) begin
        pcCnt++;
        done = 1;
        selSeen = pc_sel;
      end
      @(negedge clk);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; start = 1'b0; halt_req = 1'b0;
    modelRetired = (modelRetired + 1) % (1 << CNT_W);
    checkOutput({v.name, " wb reached"}, done, 1);
    checkOutput({v.name, " cycles"}, n, v.expCycles);
    checkOutput({v.name, " pc_sel"}, selSeen, v.expSel);
    checkOutput({v.name, " ir_load count"}, irCnt, 1);
    checkOutput({v.name, " reg_we count"}, regCnt, v.expRegWe);
    checkOutput({v.name, " pc_en count"}, pcCnt, 1);
    checkOutput({v.name, " imem_req cycles"}, imemCyc, v.iDly + 1);
    checkOutput({v.name, " dmem_req cycles"}, dmemCyc, isMem ? v.dDly + 1 : 0);
    checkOutput({v.name, " dmem_we"}, weBad, 0);
    checkOutput({v.name, " pc_en after wb"}, pc_en, 0);
    checkOutput({v.name, " busy after wb"}, busy, !v.halt);
    checkOutput({v.name, " retired"}, retired, modelRetired);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int reqCycles;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_reg_write = 1'b0; dec_data_read = 1'b0; dec_data_write = 1'b0;
    dec_branch_type = 4'b1001; dec_counter_selector = 2'b00; branch_taken = 1'b0;

    //          name     rw rd wr br       cs    tk iD dD halt sel   rwe we cyc
    vecs[0] = '{"ADD",    1, 0, 0, 4'b1001, 2'b00, 0, 0, 0, 1, 2'b00, 1, 0, 4};
    vecs[1] = '{"LW",     1, 1, 0, 4'b1001, 2'b00, 0, 0, 3, 0, 2'b00, 1, 0, 8};
    vecs[2] = '{"BEQ_T",  0, 0, 0, 4'b0001, 2'b00, 1, 0, 0, 0, 2'b11, 0, 0, 4};
    vecs[3] = '{"BEQ_N",  0, 0, 0, 4'b0001, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4};
    vecs[4] = '{"JAL",    1, 0, 0, 4'b0001, 2'b01, 1, 0, 0, 0, 2'b01, 1, 0, 4};
    vecs[5] = '{"JR",     0, 0, 0, 4'b0001, 2'b10, 1, 3, 0, 0, 2'b10, 0, 0, 7};
    vecs[6] = '{"SW",     0, 0, 1, 4'b1001, 2'b00, 0, 2, 1, 0, 2'b00, 0, 1, 8};
    vecs[7] = '{"RDWR",   1, 1, 1, 4'b1001, 2'b00, 0, 0, 3, 1, 2'b00, 1, 0, 8};
    vecs[8] = '{"NOBR",   0, 0, 0, 4'b1001, 2'b00, 1, 1, 0, 1, 2'b00, 0, 0, 5};

    #1;
    checkOutput("reset imem_req", imem_req, 0);
    checkOutput("reset dmem_req", dmem_req, 0);
    checkOutput("reset strobes", {ir_load, reg_we, pc_en, dmem_we}, 0);
    checkOutput("reset pc_sel", pc_sel, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset bus_err", bus_err, 0);
    checkOutput("reset retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (!busy) startRun();
      applyStimulus(vecs[i], 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      v.name  = "RND";
      v.rw    = 1'($urandom_range(0, 1));
      v.rd    = ($urandom_range(0, 2) == 0);
      v.wr    = ($urandom_range(0, 2) == 0);
      v.br    = ($urandom_range(0, 1) == 1) ? 4'b1001 : 4'($urandom);
      v.cs    = 2'($urandom_range(0, 3));
      v.taken = 1'($urandom_range(0, 1));
      v.iDly  = int'($urandom_range(0, TIMEOUT - 1));
      v.dDly  = int'($urandom_range(0, TIMEOUT - 1));
      v.halt  = ($urandom_range(0, 3) == 0);
      v = modelVec(v);
      if (!busy) startRun();
      applyStimulus(v, 1'b1);
    end

    // Store in flight when reset hits: everything drops, nothing retires.
    if (!busy) startRun();
    dec_reg_write = 1'b0; dec_data_read = 1'b0; dec_data_write = 1'b1;
    dec_branch_type = 4'b1001; dec_counter_selector = 2'b00;
    for (int i = 0; i < 20 && !dmem_req; i++) begin
      imem_ack = imem_req;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    checkOutput("mid-MEM dmem_req before reset", dmem_req, 1);
    checkOutput("mid-MEM dmem_we before reset", dmem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset dmem_req", dmem_req, 0);
    checkOutput("async reset dmem_we", dmem_we, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset retired", retired, 0);
    modelRetired = 0;
    @(negedge clk);
    rst_n = 1'b1;
    startRun();
    applyStimulus(vecs[0], 1'b0);

    // No instruction ack: TIMEOUT fetch cycles, then a sticky error.
    startRun();
    reqCycles = 0;
    for (int i = 0; i < 20 && !bus_err; i++) begin
      if (imem_req) reqCycles++;
      @(negedge clk);
    end
    checkOutput("timeout fetch cycles", reqCycles, TIMEOUT);
    checkOutput("timeout bus_err", bus_err, 1);
    checkOutput("timeout busy", busy, 0);
    checkOutput("timeout imem_req", imem_req, 0);
    startRun();
    imem_ack = 1'b1;
    #1;
    checkOutput("err ignores ack", ir_load, 0);
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    checkOutput("err sticky after start", bus_err, 1);
    checkOutput("err no fetch after start", imem_req, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset clears bus_err", bus_err, 0);
    checkOutput("reset clears retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
